// File: rtl/rv32m_divider.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional: define RV32M_DIV_EARLY_OUT_EN to finish zero-divisor, overflow and |a|<|b| ops in one cycle.
module rv32m_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic             kill,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             is_rem_q, is_rem_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] result_d;
   logic             done_d;

   // Operand preparation for the accept edge
   logic             is_signed_c;
   logic             a_neg_c, b_neg_c;
   logic [WIDTH-1:0] a_mag_c, b_mag_c;

   assign is_signed_c = ~funct3[0];
   assign a_neg_c     = is_signed_c & a[WIDTH-1];
   assign b_neg_c     = is_signed_c & b[WIDTH-1];
   assign a_mag_c     = a_neg_c ? (-a) : a;
   assign b_mag_c     = b_neg_c ? (-b) : b;

   // One restoring-division iteration on the current partial state
   logic [WIDTH:0]   rem_sh_c, diff_c;
   logic [WIDTH-1:0] rem_it_c, quo_it_c;
   logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

   assign rem_sh_c  = {rem_q, quo_q[WIDTH-1]};
   assign diff_c    = rem_sh_c - {1'b0, dvsr_q};
   assign rem_it_c  = diff_c[WIDTH] ? rem_sh_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
   assign quo_it_c  = {quo_q[WIDTH-2:0], ~diff_c[WIDTH]};
   assign quo_fix_c = neg_quo_q ? (-quo_it_c) : quo_it_c;
   assign rem_fix_c = neg_rem_q ? (-rem_it_c) : rem_it_c;

`ifdef RV32M_DIV_EARLY_OUT_EN
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   logic             early_c;
   logic [WIDTH-1:0] early_quo_c, early_rem_c;

   // Cases whose answer is known without iterating
   always_comb begin
      early_c     = 1'b1;
      early_quo_c = '0;
      early_rem_c = a;
      if (b == '0) begin
         early_quo_c = '1;
      end else if (is_signed_c && (a == MIN_VAL) && (b == '1)) begin
         early_quo_c = MIN_VAL;
         early_rem_c = '0;
      end else if (a_mag_c >= b_mag_c) begin
         early_c = 1'b0;
      end
   end
`endif

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvsr_d    = dvsr_q;
      is_rem_d  = is_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result;
      done_d    = 1'b0;

      if (kill) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req && funct3[2]) begin
                  is_rem_d  = funct3[1];
                  neg_quo_d = is_signed_c & (a[WIDTH-1] ^ b[WIDTH-1]) & (b != '0);
                  neg_rem_d = a_neg_c;
                  quo_d     = a_mag_c;
                  rem_d     = '0;
                  dvsr_d    = b_mag_c;
                  cnt_d     = CNT_W'(WIDTH);
                  state_d   = S_BUSY;
`ifdef RV32M_DIV_EARLY_OUT_EN
                  if (early_c) begin
                     cnt_d    = '0;
                     state_d  = S_DONE;
                     done_d   = 1'b1;
                     result_d = funct3[1] ? early_rem_c : early_quo_c;
                  end
`endif
               end
            end
            S_BUSY: begin
               quo_d = quo_it_c;
               rem_d = rem_it_c;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  result_d = is_rem_q ? rem_fix_c : quo_fix_c;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvsr_q    <= '0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result    <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvsr_q    <= dvsr_d;
         is_rem_q  <= is_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result    <= result_d;
         done      <= done_d;
         busy      <= (state_d != S_IDLE);
      end
   end

endmodule

// File: tb/tb_rv32m_divider.sv
// Scoreboard bench for rv32m_divider: result and done-cycle checked against a behavioural model.
module tb_rv32m_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        kill = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done;
   logic [31:0] result;

   rv32m_divider #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .req(req), .kill(kill), .funct3(funct3),
      .a(a), .b(b), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

`ifdef RV32M_DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t  sb[$];
   exp_t  mon_e;
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   logic  done_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv);
      logic ovf;
      ovf = !f3[0] && (av == 32'h8000_0000) && (bv == 32'hFFFF_FFFF);
      case (f3)
         3'b100:  model = (bv == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(av) / $signed(bv));
         3'b101:  model = (bv == 0) ? 32'hFFFF_FFFF : av / bv;
         3'b110:  model = (bv == 0) ? av : ovf ? 32'h0 : 32'($signed(av) % $signed(bv));
         default: model = (bv == 0) ? av : av % bv;
      endcase
   endfunction

   function automatic int lat(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv);
      logic        sgn, sp;
      logic [31:0] am, bm;
      sgn = !f3[0];
      am  = (sgn && av[31]) ? -av : av;
      bm  = (sgn && bv[31]) ? -bv : bv;
      sp  = (bv == 0) || (sgn && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) || (am < bm);
      lat = (EARLY && sp) ? 1 : 33;
   endfunction

   // Drive an op; ofs = number of edges until the accepting edge completes
   task automatic issue(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv, input int ofs);
      exp_t e;
      funct3 = f3;
      a      = av;
      b      = bv;
      req    = 1'b1;
      e.res  = model(f3, av, bv);
      e.cyc  = cyc + ofs + lat(f3, av, bv) - 1;
      sb.push_back(e);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 100);
      if (!done) begin
         check("done_timeout", 32'(done), 32'd1);
         sb.delete();
      end
   endtask

   task automatic run_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      issue(f3, av, bv, 1);
      wait_done();
      req = 1'b0;
   endtask

   // Scoreboard monitor: every done pulse must match the oldest expectation
   always @(negedge clk) begin
      if (rst && done) begin
         check("done_gap", 32'(done_prev), 32'd0);
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("result", result, mon_e.res);
            check("latency", 32'(cyc), 32'(mon_e.cyc));
         end
      end
      done_prev = done;
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op(3'b101, 32'd100, 32'd7);
      run_op(3'b111, 32'd100, 32'd7);
      run_op(3'b100, 32'hFFFF_FFF9, 32'd2);
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2);
      run_op(3'b100, 32'd5, 32'd0);
      run_op(3'b110, 32'd5, 32'd0);
      run_op(3'b110, 32'hFFFF_FFFB, 32'd0);
      run_op(3'b101, 32'd5, 32'd0);
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(3'b100, 32'd3, 32'hFFFF_FFF6);
      run_op(3'b111, 32'hFFFF_FFFF, 32'd16);

      // Flush mid-operation: no done for the killed op
      @(negedge clk);
      funct3 = 3'b101; a = 32'd1000; b = 32'd3; req = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("kill_busy_before", 32'(busy), 32'd1);
      kill = 1'b1;
      req  = 1'b0;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill_busy_after", 32'(busy), 32'd0);
      repeat (40) @(negedge clk);
      check("kill_busy_idle", 32'(busy), 32'd0);
      run_op(3'b101, 32'd9, 32'd3);

      // Kill and req together in IDLE: nothing accepted
      @(negedge clk);
      funct3 = 3'b101; a = 32'd50; b = 32'd5; req = 1'b1; kill = 1'b1;
      @(negedge clk);
      req = 1'b0; kill = 1'b0;
      check("kill_req_idle", 32'(busy), 32'd0);

      // Asynchronous reset mid-operation
      @(negedge clk);
      funct3 = 3'b101; a = 32'd1000; b = 32'd7; req = 1'b1;
      @(posedge clk);
      repeat (14) @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      rst = 1'b0;
      #1;
      check("arst_done", 32'(done), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_op(3'b101, 32'd8, 32'd2);

      // Back-to-back with req held across done
      @(negedge clk);
      issue(3'b101, 32'd21, 32'd3, 1);
      wait_done();
      issue(3'b101, 32'd20, 32'd4, 2);
      wait_done();
      req = 1'b0;

      for (int i = 0; i < 8; i++) begin
         logic [2:0]  f3;
         logic [31:0] av, bv;
         f3 = 3'(4 + $urandom_range(0, 3));
         av = $urandom;
         bv = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
         run_op(f3, av, bv);
      end
      run_op(3'b111, 32'd7, 32'd9);

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
